// File: rtl/demux_1x8.sv
// 1-to-8 registered demultiplexer: each of eight lanes holds one word until acked.
// Optional macro DEMUX_AUTO_SEL_EN replaces sel with an internal round-robin lane pointer.
module demux_1x8 #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         sel,
    output logic [8*WIDTH-1:0] out_bus,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ack,
    output logic [2:0]         cur_sel
);

    logic [WIDTH-1:0] lane_p0 [8];
    logic [7:0]       vld_p0;
    logic [2:0]       sel_w;
    logic             accept;

`ifdef DEMUX_AUTO_SEL_EN
    logic [2:0] ptr_q;
    logic [2:0] unused_sel;

    assign unused_sel = sel;
    assign sel_w      = ptr_q;

    // Pointer advances only on an accepted write, so a stalled lane holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else if (accept) begin
            ptr_q <= ptr_q + 3'd1;
        end
    end
`else
    assign sel_w = sel;
`endif

    assign cur_sel  = sel_w;
    assign in_ready = ~vld_p0[sel_w] | out_ack[sel_w];
    assign accept   = in_valid & in_ready;

    // Lane registers: a write to a lane takes priority over its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 8'h00;
            for (int n = 0; n < 8; n++) begin
                lane_p0[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (accept && (sel_w == 3'(n))) begin
                    lane_p0[n] <= in_data;
                    vld_p0[n]  <= 1'b1;
                end else if (out_ack[n]) begin
                    vld_p0[n]  <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_bus
        assign out_bus[g*WIDTH +: WIDTH] = lane_p0[g];
    end

    assign out_valid = vld_p0;

endmodule

// File: tb/tb_demux_1x8.sv
// Directed bench for demux_1x8 (WIDTH=4); auto-select scenarios build when DEMUX_AUTO_SEL_EN is defined.
module tb_demux_1x8;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         sel;
    logic [8*WIDTH-1:0] out_bus;
    logic [7:0]         out_valid;
    logic [7:0]         out_ack;
    logic [2:0]         cur_sel;

    int n_checks = 0;
    int n_errors = 0;

    demux_1x8 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .out_bus  (out_bus),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .cur_sel  (cur_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] lane(input int n);
        return out_bus[n*WIDTH +: WIDTH];
    endfunction

    logic [3:0] sweep [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h8, 4'h7};

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        sel      = 3'd0;
        out_ack  = 8'h00;
        #2;
        check("rst_valid", 32'(out_valid), 32'h00);
        check("rst_bus", out_bus, 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        check("rst_cur_sel", 32'(cur_sel), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef DEMUX_AUTO_SEL_EN
        // Sweep all lanes, watching valid grow one cycle after each accept.
        for (int i = 0; i < 8; i++) begin
            sel      = 3'(i);
            in_data  = sweep[i];
            in_valid = 1'b1;
            #1;
            check("sweep_ready", 32'(in_ready), 32'h1);
            check("sweep_cur_sel", 32'(cur_sel), 32'(i));
            tick();
            check("sweep_valid", 32'(out_valid), 32'((9'h1 << (i + 1)) - 9'h1));
        end
        in_valid = 1'b0;
        #1;
        check("sweep_all_valid", 32'(out_valid), 32'hFF);
        check("sweep_bus", out_bus, 32'h78FEDCBA);

        // Stall on full lane 3, then same-edge ack and accept.
        sel      = 3'd3;
        in_data  = 4'h5;
        in_valid = 1'b1;
        #1;
        check("stall_ready", 32'(in_ready), 32'h0);
        tick();
        check("stall_lane3", 32'(lane(3)), 32'hD);
        check("stall_valid", 32'(out_valid), 32'hFF);
        out_ack = 8'h08;
        #1;
        check("ackwr_ready", 32'(in_ready), 32'h1);
        tick();
        out_ack  = 8'h00;
        in_valid = 1'b0;
        check("ackwr_lane3", 32'(lane(3)), 32'h5);
        check("ackwr_valid", 32'(out_valid), 32'hFF);

        // Ack lanes 0 and 7 with no write: valid clears, data stays.
        out_ack = 8'h81;
        tick();
        out_ack = 8'h00;
        check("ack_valid", 32'(out_valid), 32'h7E);
        check("ack_bus", out_bus, 32'h78FE5CBA);

        // Acks on empty lanes are ignored.
        out_ack = 8'h81;
        tick();
        out_ack = 8'h00;
        check("ack_empty_valid", 32'(out_valid), 32'h7E);
        check("ack_empty_bus", out_bus, 32'h78FE5CBA);

        // Ack on lane 1 while writing lane 0: independent paths.
        sel      = 3'd0;
        in_data  = 4'h1;
        in_valid = 1'b1;
        out_ack  = 8'h02;
        tick();
        in_valid = 1'b0;
        out_ack  = 8'h00;
        check("mixed_valid", 32'(out_valid), 32'h7D);
        check("mixed_bus", out_bus, 32'h78FE5CB1);

        // Asynchronous reset mid-cycle with lanes full.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h00);
        check("arst_bus", out_bus, 32'h0);
        check("arst_ready", 32'(in_ready), 32'h1);
        #1;
        rst_n    = 1'b1;
        sel      = 3'd4;
        in_data  = 4'h9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'h10);
        check("post_rst_bus", out_bus, 32'h00090000);
`else
        // Nine accepts of 1..9, acking each lane the cycle after its write; sel toggles freely.
        for (int k = 0; k < 9; k++) begin
            in_data  = 4'(k + 1);
            in_valid = 1'b1;
            sel      = 3'(7 - k);
            out_ack  = (k > 0) ? (8'h01 << ((k - 1) % 8)) : 8'h00;
            #1;
            check("auto_cur_sel", 32'(cur_sel), 32'(k % 8));
            check("auto_ready", 32'(in_ready), 32'h1);
            tick();
        end
        in_valid = 1'b0;
        out_ack  = 8'h00;
        #1;
        check("auto_lane0", 32'(lane(0)), 32'h9);
        check("auto_bus", out_bus, 32'h87654329);
        check("auto_valid", 32'(out_valid), 32'h01);
        check("auto_ptr_wrap", 32'(cur_sel), 32'h1);

        // Reset, fill all lanes, free lanes 0 and 1, refill them so the pointer sits on full lane 2.
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h00);
        check("arst_cur_sel", 32'(cur_sel), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data  = 4'(k + 1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ack  = 8'h03;
        tick();
        out_ack = 8'h00;
        for (int k = 0; k < 2; k++) begin
            in_data  = 4'hC;
            in_valid = 1'b1;
            tick();
        end
        in_data = 4'hE;
        #1;
        check("astall_cur_sel", 32'(cur_sel), 32'h2);
        check("astall_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        check("astall_hold", 32'(cur_sel), 32'h2);
        check("astall_lane2", 32'(lane(2)), 32'h3);
        out_ack = 8'h04;
        #1;
        check("astall_ack_ready", 32'(in_ready), 32'h1);
        tick();
        out_ack  = 8'h00;
        in_valid = 1'b0;
        check("astall_advance", 32'(cur_sel), 32'h3);
        check("astall_lane2_new", 32'(lane(2)), 32'hE);
        check("astall_valid", 32'(out_valid), 32'hFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_1x8.md
DEMUX_1X8 -- requirements
Module: demux_1x8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, lane data width in bits.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_data, input, WIDTH, write data.
REQ-005 The block SHALL have port in_valid, input, 1, write request.
REQ-006 The block SHALL have port in_ready, output, 1, target lane able to accept this cycle.
REQ-007 The block SHALL have port sel, input, 3, target lane index 0..7 (ignored when DEMUX_AUTO_SEL_EN is defined).
REQ-008 The block SHALL have port out_bus, output, 8*WIDTH, lane n held data on bits [n*WIDTH +: WIDTH].
REQ-009 The block SHALL have port out_valid, output, 8, per-lane "holds unconsumed data" flag.
REQ-010 The block SHALL have port out_ack, input, 8, per-lane consume strobe.
REQ-011 The block SHALL have port cur_sel, output, 3, lane index targeted this cycle.

Function
REQ-012 The block SHALL write in_data into lane cur_sel, and set out_valid[cur_sel], on a clock edge where in_valid && in_ready (accept).
REQ-013 The block SHALL make out_bus and out_valid reflect an accepted write exactly 1 cycle after the accept edge; no combinational path from in_data to out_bus.
REQ-014 The block SHALL drive in_ready = ~out_valid[cur_sel] | out_ack[cur_sel], combinationally.
REQ-015 The block SHALL leave lane data and valid unchanged on a cycle with in_valid=1, in_ready=0 (stall); the writer holds in_data.
REQ-016 The block SHALL clear out_valid[n] on an edge where out_ack[n]=1 and lane n is not written that cycle.
REQ-017 The block SHALL keep out_valid[n]=1 and load the new data on simultaneous ack and accept to the same lane (write wins).
REQ-018 The block SHALL ignore out_ack[n] when out_valid[n]=0; no state change.
REQ-019 The block SHALL retain a lane's data after its ack; only out_valid clears.
REQ-020 The block SHALL allow acks on any subset of lanes in the same cycle, each independent of the write path.
REQ-021 The block SHALL drive cur_sel = sel when DEMUX_AUTO_SEL_EN is undefined.
REQ-022 The block SHALL allow sel to change on any cycle; each accept uses the sel sampled at that edge.

Reset
REQ-023 The block SHALL, on rst_n low, immediately drive out_bus = 0, out_valid = 8'h00, and the internal lane pointer = 0, regardless of clk.
REQ-024 The block SHALL discard any write in progress when reset asserts mid-operation; no lane retains data after reset.
REQ-025 The block SHALL accept a write on the first rising clk edge after rst_n deasserts, with in_ready = 1 since all lanes are empty.

Configuration
REQ-026 The block SHALL, when macro DEMUX_AUTO_SEL_EN is defined, ignore sel and drive cur_sel from an internal 3-bit lane pointer.
REQ-027 The block SHALL increment the lane pointer by 1 on each accept, wrapping 7 -> 0, and hold it on stall.
REQ-028 The block SHALL, when DEMUX_AUTO_SEL_EN is undefined, contain no lane pointer; cur_sel follows sel.

Verification
REQ-029 The bench SHALL check reset: assert rst_n=0 mid-cycle with lanes full -> out_valid=00 and out_bus=0 immediately, in_ready=1.
REQ-030 The bench SHALL check the sel sweep: sel=0..7 with in_data=A,B,C,D,E,F,8,7, in_valid=1 -> out_valid=FF, out_bus=32'h78FEDCBA one cycle after the last accept.
REQ-031 The bench SHALL check stall: lane 3 full, no ack, sel=3, in_valid=1, in_data=5 -> in_ready=0, lane 3 keeps D; then out_ack[3]=1 -> same-edge accept, lane 3=5, out_valid[3] stays 1.
REQ-032 The bench SHALL check ack: out_ack=8'h81 with lanes 0 and 7 full, no write -> out_valid clears bits 0 and 7, data unchanged.
REQ-033 The bench SHALL check auto-select with DEMUX_AUTO_SEL_EN defined: 9 accepts of 1..9 with acks of each lane after the write -> cur_sel 0..7,0, lane 0 ends holding 9; sel toggling has no effect.
REQ-034 The bench SHALL check auto-select stall with DEMUX_AUTO_SEL_EN defined: lane 2 full and cur_sel=2 -> pointer holds at 2 until out_ack[2], then advances to 3 after the accept.
